nest_checker: RTL and testbench

Streaming keyword-nesting checker that consumes one ASCII byte per valid cycle and tracks `begin`/`end` block nesting, with optional `fork`/`join` pairs tracked on a type stack. It replaces the fixed single-pair block checker in the character-stream exercises. The depth range is parameterised. Overflow and mismatch are reported as sticky errors. Outputs are registered, so the checker can be placed directly in front of a status display or a scoring unit.

---
 rtl/nest_checker.sv | 151 +++++++++++++++
 tb/tb_nest_checker.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/nest_checker.sv
// Streaming begin/end nesting checker with sticky error and registered outputs.
// Define NEST_CHECKER_FORK_EN to also track fork/join pairs on a 1-bit kind stack.
module nest_checker #(
    parameter int unsigned DEPTH_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in,
    input  logic               in_valid,
    output logic               balanced,
    output logic [DEPTH_W-1:0] depth,
    output logic               err
);

    localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;
    localparam int unsigned        N_ENTRY   = (2 ** DEPTH_W) - 1;

    typedef enum logic [4:0] {
        IDLE, B, BE, BEG, BEGI, M_BEGIN,
        E, EN, M_END,
        F, FO, FOR, M_FORK,
        J, JO, JOI, M_JOIN,
        DEAD
    } state_e;

    state_e             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic               bal_q, bal_d;

    logic [7:0]         ch;
    logic               is_space;
    logic               open_c, close_c;
    logic               push;
    logic               mismatch;

`ifdef NEST_CHECKER_FORK_EN
    logic [N_ENTRY:1]   kind_q;
    logic               kind_c;
    logic               top_kind;
`endif

    always_comb begin
        ch = in;
        if (in >= 8'h41 && in <= 8'h5A) ch = in | 8'h20;
    end

    assign is_space = (in == 8'h20);

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            if (is_space) begin
                state_d = IDLE;
            end else begin
                state_d = DEAD;
                case (state_q)
                    IDLE: begin
                        if (ch == "b")      state_d = B;
                        else if (ch == "e") state_d = E;
`ifdef NEST_CHECKER_FORK_EN
                        else if (ch == "f") state_d = F;
                        else if (ch == "j") state_d = J;
`endif
                    end
                    B:    if (ch == "e") state_d = BE;
                    BE:   if (ch == "g") state_d = BEG;
                    BEG:  if (ch == "i") state_d = BEGI;
                    BEGI: if (ch == "n") state_d = M_BEGIN;
                    E:    if (ch == "n") state_d = EN;
                    EN:   if (ch == "d") state_d = M_END;
                    F:    if (ch == "o") state_d = FO;
                    FO:   if (ch == "r") state_d = FOR;
                    FOR:  if (ch == "k") state_d = M_FORK;
                    J:    if (ch == "o") state_d = JO;
                    JO:   if (ch == "i") state_d = JOI;
                    JOI:  if (ch == "n") state_d = M_JOIN;
                    default: state_d = DEAD;
                endcase
            end
        end
    end

`ifdef NEST_CHECKER_FORK_EN
    assign open_c  = in_valid && is_space && (state_q == M_BEGIN || state_q == M_FORK);
    assign close_c = in_valid && is_space && (state_q == M_END   || state_q == M_JOIN);
    assign kind_c  = (state_q == M_FORK) || (state_q == M_JOIN);

    // Mux the top-of-stack entry explicitly so depth 0 never indexes outside the stack.
    always_comb begin
        top_kind = 1'b0;
        for (int unsigned i = 1; i <= N_ENTRY; i++) begin
            if (depth_q == DEPTH_W'(i)) top_kind = kind_q[i];
        end
    end

    assign mismatch = (top_kind != kind_c);
`else
    assign open_c   = in_valid && is_space && (state_q == M_BEGIN);
    assign close_c  = in_valid && is_space && (state_q == M_END);
    assign mismatch = 1'b0;
`endif

    always_comb begin
        depth_d = depth_q;
        err_d   = err_q;
        push    = 1'b0;
        if (open_c) begin
            if (depth_q == MAX_DEPTH) begin
                err_d = 1'b1;
            end else begin
                depth_d = depth_q + 1'b1;
                push    = 1'b1;
            end
        end else if (close_c) begin
            if (depth_q == '0 || mismatch) begin
                err_d = 1'b1;
            end else begin
                depth_d = depth_q - 1'b1;
            end
        end
        bal_d = !err_d && (depth_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            depth_q <= '0;
            err_q   <= 1'b0;
            bal_q   <= 1'b1;
`ifdef NEST_CHECKER_FORK_EN
            kind_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            bal_q   <= bal_d;
`ifdef NEST_CHECKER_FORK_EN
            for (int unsigned i = 1; i <= N_ENTRY; i++) begin
                if (push && depth_d == DEPTH_W'(i)) kind_q[i] <= kind_c;
            end
`endif
        end
    end

    assign depth    = depth_q;
    assign err      = err_q;
    assign balanced = bal_q;

endmodule

// File: tb/tb_nest_checker.sv
// Directed self-checking bench for nest_checker; a second instance with DEPTH_W=2 covers overflow.
module tb_nest_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in = 8'h00;
    logic       in_valid = 1'b0;

    logic       bal4, err4;
    logic [3:0] depth4;
    logic       bal2, err2;
    logic [1:0] depth2;

    int tests  = 0;
    int failed = 0;

    nest_checker #(.DEPTH_W(4)) dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .balanced(bal4), .depth(depth4), .err(err4)
    );

    nest_checker #(.DEPTH_W(2)) dut2 (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .balanced(bal2), .depth(depth2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int d, input int e, input int b);
        chk({tag, ".depth"},    32'(depth4), 32'(d));
        chk({tag, ".err"},      32'(err4),   32'(e));
        chk({tag, ".balanced"}, 32'(bal4),   32'(b));
    endtask

    task automatic send_byte(input byte b);
        in       = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk3("reset", 0, 0, 1);
        chk("reset.dut2.depth", 32'(depth2), 0);
        chk("reset.dut2.bal", 32'(bal2), 1);
        reset = 1'b1;

        send_str(" BEgIn");
        chk3("t1.pre_space", 0, 0, 1);
        send_byte(" ");
        chk3("t1.open", 1, 0, 0);
        send_str("End ");
        chk3("t1.close", 0, 0, 1);

        do_reset();
        send_str(" end ");
        chk3("t2.underflow", 0, 1, 0);
        send_str("begin ");
        chk3("t2.sticky", 1, 1, 0);
        do_reset();
        chk3("t2.reset", 0, 0, 1);

        do_reset();
        send_str(" begin endc endv ");
        chk3("t3.non_kw", 1, 0, 0);
        send_str("end ");
        chk3("t3.close", 0, 0, 1);

        do_reset();
        send_str("begin begin begin ");
        chk("t4.d3.depth", 32'(depth2), 3);
        chk("t4.d3.err", 32'(err2), 0);
        send_str("begin ");
        chk("t4.ovf.depth", 32'(depth2), 3);
        chk("t4.ovf.err", 32'(err2), 1);
        chk("t4.ovf.bal", 32'(bal2), 0);
        chk3("t4.wide", 4, 0, 0);

        do_reset();
        send_str(" fork begin join ");
`ifdef NEST_CHECKER_FORK_EN
        chk3("t5.mismatch", 2, 1, 0);
`else
        chk3("t5.plain", 1, 0, 0);
`endif
        do_reset();
        send_str(" fork begin end ");
`ifdef NEST_CHECKER_FORK_EN
        chk3("t5.inner", 1, 0, 0);
`else
        chk3("t5.inner", 0, 0, 1);
`endif
        send_str("join ");
        chk3("t5.pairs", 0, 0, 1);

        do_reset();
        send_str("beg");
        in = 8'h20;
        repeat (3) @(posedge clk);
        #1;
        chk3("t6.hold", 0, 0, 1);
        send_str("in");
        chk3("t6.no_space", 0, 0, 1);
        send_byte(" ");
        chk3("t6.split", 1, 0, 0);

        do_reset();
        send_str("begin begi");
        chk3("t7.pre", 1, 0, 0);
        reset = 1'b0;
        #2;
        chk3("t7.async", 0, 0, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_str("n ");
        chk3("t7.discard", 0, 0, 1);
        send_str(" end ");
        chk3("t7.after", 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
